watch_set_controller: RTL

Mode and set-position sequencer for the digital watch time-keeping datapath. It turns three raw push buttons into four outputs for the time counter: the normal/setting mode bit, the one-hot field-select code, the display blink flag, and a single-cycle increment pulse. It debounces the buttons, runs the setting-mode state machine, and can optionally return the watch to normal mode after a period with no button activity.

---
 rtl/watch_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/watch_set_controller.sv | 101 ++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared constants and state type for the watch time-keeping datapath.
package watch_pkg;

  localparam logic [2:0] POS_HOUR = 3'b100;
  localparam logic [2:0] POS_MIN  = 3'b010;
  localparam logic [2:0] POS_SEC  = 3'b001;
  localparam logic [2:0] POS_NONE = 3'b000;

  localparam logic MODE_NORMAL  = 1'b0;
  localparam logic MODE_SETTING = 1'b1;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } set_state_t;

  function automatic logic [2:0] pos_of(set_state_t s);
    case (s)
      ST_SET_HOUR: pos_of = POS_HOUR;
      ST_SET_MIN:  pos_of = POS_MIN;
      ST_SET_SEC:  pos_of = POS_SEC;
      default:     pos_of = POS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and
// rising-edge event on the accepted level.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  logic        sync_p0, sync_p1;
  logic        fill_p0, fill_p1;
  logic        armed;
  logic [19:0] cnt;
  logic        accept;

  assign accept = (sync_p1 != level) && (cnt == DEBOUNCE_CYCLES - 20'd1);

  // Events are only armed once the button has been seen released after
  // reset, so a button held through reset never produces a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      fill_p0 <= 1'b0;
      fill_p1 <= 1'b0;
      armed   <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      fill_p0 <= 1'b1;
      fill_p1 <= fill_p0;
      if (fill_p1 && !sync_p1 && !level)
        armed <= 1'b1;
      rise <= accept && sync_p1 && armed;
      if ((sync_p1 == level) || accept)
        cnt <= '0;
      else
        cnt <= cnt + 20'd1;
      if (accept)
        level <= sync_p1;
    end
  end

endmodule

// File: rtl/watch_set_controller.sv
// Watch mode / set-position sequencer. Optional inactivity auto-exit is
// enabled with the WATCH_SET_TIMEOUT_EN macro.
module watch_set_controller
  import watch_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter int          TIMEOUT_S       = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_mode,
  input  logic       btn_pos,
  input  logic       btn_inc,
  output logic       mode,
  output logic [2:0] set_pos,
  output logic       blink,
  output logic       inc_pulse
);

  set_state_t state, state_nxt;
  logic       ev_mode, ev_pos, ev_inc, ev_any;
  logic       timeout_hit;
  logic       blink_nxt;
  logic [2:0] unused_level;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .reset(reset), .btn_raw(btn_mode),
    .level(unused_level[0]), .rise(ev_mode)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pos (
    .clk(clk), .reset(reset), .btn_raw(btn_pos),
    .level(unused_level[1]), .rise(ev_pos)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .reset(reset), .btn_raw(btn_inc),
    .level(unused_level[2]), .rise(ev_inc)
  );

  assign ev_any = ev_mode | ev_pos | ev_inc;

`ifdef WATCH_SET_TIMEOUT_EN
  logic [5:0] idle_s;

  assign timeout_hit = (state != ST_NORMAL) && (idle_s == 6'(TIMEOUT_S));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      idle_s <= '0;
    else if ((state == ST_NORMAL) || ev_any || timeout_hit)
      idle_s <= '0;
    else if (tick_1hz)
      idle_s <= idle_s + 6'd1;
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = tick_1hz ^ ev_any ^ (TIMEOUT_S > 63);
`endif

  // Mode beats position; any button event cancels a pending timeout.
  always_comb begin
    state_nxt = state;
    if (ev_mode) begin
      state_nxt = (state == ST_NORMAL) ? ST_SET_HOUR : ST_NORMAL;
    end else if (ev_pos) begin
      case (state)
        ST_SET_HOUR: state_nxt = ST_SET_MIN;
        ST_SET_MIN:  state_nxt = ST_SET_SEC;
        ST_SET_SEC:  state_nxt = ST_SET_HOUR;
        default:     state_nxt = state;
      endcase
    end else if (timeout_hit && !ev_inc) begin
      state_nxt = ST_NORMAL;
    end

    blink_nxt = 1'b0;
    if ((state_nxt == state) && (state != ST_NORMAL))
      blink_nxt = blink ^ tick_2hz;
  end

  // Outputs are registered from the next state so they move with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_NORMAL;
      mode      <= MODE_NORMAL;
      set_pos   <= POS_NONE;
      blink     <= 1'b0;
      inc_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode      <= (state_nxt == ST_NORMAL) ? MODE_NORMAL : MODE_SETTING;
      set_pos   <= pos_of(state_nxt);
      blink     <= blink_nxt;
      inc_pulse <= ev_inc && !ev_mode && (state != ST_NORMAL);
    end
  end

endmodule
